radar_azimuth_decoder: RTL and testbench

Receiving end of the radar ACP/ARP/trigger interface. Samples the asynchronous `acp_in`, `arp_in` and `trig_in` lines, tracks antenna azimuth as an ACP count, re-indexes it to zero at each ARP, and checks every revolution for exactly `ACP_PER_REV` pulses. Sits downstream of the radar/clutter simulator, or of a real antenna encoder, and feeds azimuth-tagged trigger events to the clutter/video processing path.

---
 rtl/radar_azimuth_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_radar_azimuth_decoder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_azimuth_decoder.sv
// -----------------------------------------------------------------------------
// radar_azimuth_decoder
//
// Receiving end of the radar ACP/ARP/trigger interface. Conditions the three
// asynchronous radar lines, tracks antenna azimuth as an ACP count that is
// re-indexed to zero on every ARP-qualified ACP edge (index event), checks each
// revolution for exactly ACP_PER_REV pulses and tags radar triggers with the
// azimuth at which they arrived.
//
// Parameters:
//   ACP_PER_REV  ACP pulses per revolution (power of two, <= 2**AZ_W)
//   AZ_W         azimuth width
//   WDOG_CYC     clk cycles without an ACP edge before the input is stale
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   acp_in       ACP pulse train (async)
//   arp_in       ARP north marker, only high during an ACP high phase (async)
//   trig_in      radar trigger (async)
//   err_clr      synchronous clear of cnt_err
//   azimuth      current azimuth count
//   az_valid     high while locked
//   az_strobe    1-cycle pulse on every azimuth update
//   rev_strobe   1-cycle pulse on every index event
//   rev_count    index events since reset (wraps)
//   trig_strobe  1-cycle pulse per trigger rising edge
//   trig_az      azimuth captured at the last trigger
//   cnt_err      sticky per-revolution ACP count error
//   stale        high while the ACP input is stale
//   rev_period   clk cycles between the last two locked index events
//   period_valid 1-cycle pulse when rev_period updates
//
// Build option:
//   RADAR_DEC_PERIOD_EN  enables the revolution period counter; when undefined
//                        rev_period and period_valid are tied to 0.
// -----------------------------------------------------------------------------
module radar_azimuth_decoder #(
    parameter int unsigned ACP_PER_REV = 4096,
    parameter int unsigned AZ_W        = 12,
    parameter int unsigned WDOG_CYC    = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acp_in,
    input  logic            arp_in,
    input  logic            trig_in,
    input  logic            err_clr,
    output logic [AZ_W-1:0] azimuth,
    output logic            az_valid,
    output logic            az_strobe,
    output logic            rev_strobe,
    output logic [15:0]     rev_count,
    output logic            trig_strobe,
    output logic [AZ_W-1:0] trig_az,
    output logic            cnt_err,
    output logic            stale,
    output logic [31:0]     rev_period,
    output logic            period_valid
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_STALE    = 2'd2;

    localparam logic [AZ_W-1:0] AZ_LAST  = AZ_W'(ACP_PER_REV - 1);
    localparam logic [AZ_W:0]   EDGE_OK  = (AZ_W+1)'(ACP_PER_REV - 1);
    localparam logic [15:0]     WDOG_MAX = 16'(WDOG_CYC);

    // Bit order in the conditioning pipeline: [0]=ACP, [1]=ARP, [2]=trigger
    logic [2:0] sync1, sync2, prev, rise_q;
    logic       arp_lvl_q;

    logic [1:0]      state;
    logic            arp_pend;
    logic [AZ_W:0]   edge_cnt;
    logic [15:0]     wdog, wdog_nxt;
    logic [AZ_W-1:0] az_inc;
    logic            acp_rise, arp_rise, trig_rise;
    logic            idx, step, err_set;

    // Two-flop synchronizer, then a registered rising-edge pulse. The ARP level
    // is delayed by one stage too so it lines up with the registered ACP edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            rise_q    <= '0;
            arp_lvl_q <= 1'b0;
        end else begin
            sync1     <= {trig_in, arp_in, acp_in};
            sync2     <= sync1;
            prev      <= sync2;
            rise_q    <= sync2 & ~prev;
            arp_lvl_q <= sync2[1];
        end
    end

    assign acp_rise  = rise_q[0];
    assign arp_rise  = rise_q[1];
    assign trig_rise = rise_q[2];

    assign idx     = acp_rise & (arp_pend | arp_lvl_q);
    assign step    = acp_rise & ~idx;
    assign err_set = idx && (state == ST_LOCKED) && (edge_cnt != EDGE_OK);

    assign az_valid = (state == ST_LOCKED);
    assign stale    = (state == ST_STALE);

    always_comb begin
        az_inc = (azimuth == AZ_LAST) ? '0 : azimuth + AZ_W'(1);
    end

    always_comb begin
        wdog_nxt = wdog;
        if (acp_rise)
            wdog_nxt = '0;
        else if (wdog != WDOG_MAX)
            wdog_nxt = wdog + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_UNLOCKED;
            arp_pend    <= 1'b0;
            edge_cnt    <= '0;
            wdog        <= '0;
            azimuth     <= '0;
            az_strobe   <= 1'b0;
            rev_strobe  <= 1'b0;
            rev_count   <= '0;
            trig_strobe <= 1'b0;
            trig_az     <= '0;
            cnt_err     <= 1'b0;
        end else begin
            az_strobe   <= 1'b0;
            rev_strobe  <= 1'b0;
            trig_strobe <= trig_rise;
            wdog        <= wdog_nxt;

            // Captures the register value before this cycle's update
            if (trig_rise)
                trig_az <= azimuth;

            if (idx)
                arp_pend <= 1'b0;
            else if (arp_rise)
                arp_pend <= 1'b1;

            if (err_set)
                cnt_err <= 1'b1;
            else if (err_clr)
                cnt_err <= 1'b0;

            if (idx) begin
                state      <= ST_LOCKED;
                azimuth    <= '0;
                az_strobe  <= 1'b1;
                rev_strobe <= 1'b1;
                rev_count  <= rev_count + 16'd1;
                edge_cnt   <= '0;
            end else begin
                if (step && (edge_cnt != '1))
                    edge_cnt <= edge_cnt + (AZ_W+1)'(1);

                case (state)
                    ST_LOCKED: begin
                        if (step) begin
                            azimuth   <= az_inc;
                            az_strobe <= 1'b1;
                        end
                        // Expiry is taken on the edge the counter reaches the
                        // limit, so stale and the full count appear together.
                        if (wdog_nxt == WDOG_MAX)
                            state <= ST_STALE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RADAR_DEC_PERIOD_EN
    logic [31:0] per_cnt, per_inc;

    // Loading the incremented value makes rev_period the full edge-to-edge
    // cycle distance rather than one less.
    always_comb begin
        per_inc = (per_cnt == '1) ? per_cnt : per_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt      <= '0;
            rev_period   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (idx) begin
                per_cnt <= '0;
                if (state == ST_LOCKED) begin
                    rev_period   <= per_inc;
                    period_valid <= 1'b1;
                end
            end else begin
                per_cnt <= per_inc;
            end
        end
    end
`else
    assign rev_period   = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_radar_azimuth_decoder.sv
// -----------------------------------------------------------------------------
// tb_radar_azimuth_decoder
//
// Self-checking bench for radar_azimuth_decoder with a reduced geometry
// (64 ACP per revolution, 8-bit azimuth, 300-cycle watchdog). ACP pulses are
// randomised in width and spacing; an event-level model predicts azimuth, lock
// state, revolution count and the sticky count error after every pulse.
// -----------------------------------------------------------------------------
module tb_radar_azimuth_decoder;

    localparam int ACP  = 64;
    localparam int AZW  = 8;
    localparam int WDOG = 300;
    localparam int EMAX = (1 << (AZW + 1)) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           acp_in = 1'b0;
    logic           arp_in = 1'b0;
    logic           trig_in = 1'b0;
    logic           err_clr = 1'b0;
    logic [AZW-1:0] azimuth;
    logic           az_valid;
    logic           az_strobe;
    logic           rev_strobe;
    logic [15:0]    rev_count;
    logic           trig_strobe;
    logic [AZW-1:0] trig_az;
    logic           cnt_err;
    logic           stale;
    logic [31:0]    rev_period;
    logic           period_valid;

    radar_azimuth_decoder #(
        .ACP_PER_REV (ACP),
        .AZ_W        (AZW),
        .WDOG_CYC    (WDOG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .acp_in       (acp_in),
        .arp_in       (arp_in),
        .trig_in      (trig_in),
        .err_clr      (err_clr),
        .azimuth      (azimuth),
        .az_valid     (az_valid),
        .az_strobe    (az_strobe),
        .rev_strobe   (rev_strobe),
        .rev_count    (rev_count),
        .trig_strobe  (trig_strobe),
        .trig_az      (trig_az),
        .cnt_err      (cnt_err),
        .stale        (stale),
        .rev_period   (rev_period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    int m_state;   // 0 unlocked, 1 locked, 2 stale
    int m_az, m_edges, m_err, m_rev, m_pend;
    int e_az = 0, e_rev = 0, e_trig = 0, e_per = 0;

    task automatic model_reset();
        m_state = 0; m_az = 0; m_edges = 0; m_err = 0; m_rev = 0; m_pend = 0;
    endtask

    task automatic model_pulse(input bit arp_on, input bit late);
        if (arp_on || m_pend) begin
            if (m_state == 1) begin
                if (m_edges != ACP - 1) m_err = 1;
                e_per++;
            end
            m_edges = 0;
            m_rev   = (m_rev + 1) % 65536;
            m_az    = 0;
            m_state = 1;
            m_pend  = 0;
            e_az++;
            e_rev++;
        end else begin
            if (m_edges < EMAX) m_edges++;
            if (m_state == 1) begin
                m_az = (m_az + 1) % ACP;
                e_az++;
            end
        end
        if (late) m_pend = 1;
    endtask

    // ---------------- strobe monitor ----------------
    int n_az = 0, n_rev = 0, n_trig = 0, n_per = 0, dbl = 0;
    int last_az_cyc = 0, last_rev_cyc = 0;
    logic p_az = 1'b0, p_rev = 1'b0, p_trig = 1'b0;

    always @(negedge clk) begin
        if (az_strobe) begin n_az++; last_az_cyc = cyc; end
        if (trig_strobe) n_trig++;
        if (period_valid) begin
            n_per++;
`ifdef RADAR_DEC_PERIOD_EN
            check("period_len", rev_period, cyc - last_rev_cyc);
            check("period_align", rev_strobe, 1);
`endif
        end
        if (rev_strobe) begin n_rev++; last_rev_cyc = cyc; end
        if ((az_strobe && p_az) || (rev_strobe && p_rev) || (trig_strobe && p_trig)) dbl++;
        p_az = az_strobe; p_rev = rev_strobe; p_trig = trig_strobe;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_state(input string tag);
        check({tag, ".az"},    azimuth,   m_az);
        check({tag, ".valid"}, az_valid,  m_state == 1);
        check({tag, ".stale"}, stale,     m_state == 2);
        check({tag, ".rev"},   rev_count, m_rev);
        check({tag, ".err"},   cnt_err,   m_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".az"},     azimuth,      0);
        check({tag, ".valid"},  az_valid,     0);
        check({tag, ".azs"},    az_strobe,    0);
        check({tag, ".revs"},   rev_strobe,   0);
        check({tag, ".rev"},    rev_count,    0);
        check({tag, ".trgs"},   trig_strobe,  0);
        check({tag, ".trgaz"},  trig_az,      0);
        check({tag, ".err"},    cnt_err,      0);
        check({tag, ".stale"},  stale,        0);
        check({tag, ".period"}, rev_period,   0);
        check({tag, ".pvalid"}, period_valid, 0);
    endtask

    // One ACP pulse, driven from a falling clock edge. A late ARP rises two
    // cycles into the high phase and arms the next ACP as the index.
    task automatic do_pulse(input string tag, input bit arp_on, input bit late);
        int hi, lo;
        hi = late ? int'($urandom_range(4, 6)) : int'($urandom_range(2, 5));
        lo = $urandom_range(2, 5);
        acp_in = 1'b1;
        arp_in = arp_on;
        if (late) begin
            repeat (2) @(negedge clk);
            arp_in = 1'b1;
            repeat (hi - 2) @(negedge clk);
        end else begin
            repeat (hi) @(negedge clk);
        end
        acp_in = 1'b0;
        arp_in = 1'b0;
        repeat (lo) @(negedge clk);
        model_pulse(arp_on, late);
        check_state(tag);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        m_err = 0;
        check("err_clr", cnt_err, 0);
    endtask

    // Trigger and a plain ACP edge entering the same cycle; checks the exact
    // input-to-output latency and the pre-update capture.
    task automatic coinc(input string tag);
        int az0;
        az0 = m_az;
        acp_in  = 1'b1;
        trig_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".pre_az"},   azimuth,     az0);
        check({tag, ".pre_azs"},  az_strobe,   0);
        check({tag, ".pre_trgs"}, trig_strobe, 0);
        @(posedge clk);
        #1;
        check({tag, ".az"},    azimuth,     (az0 + 1) % ACP);
        check({tag, ".trgaz"}, trig_az,     az0);
        check({tag, ".azs"},   az_strobe,   1);
        check({tag, ".trgs"},  trig_strobe, 1);
        check({tag, ".revs"},  rev_strobe,  0);
        @(negedge clk);
        acp_in  = 1'b0;
        trig_in = 1'b0;
        repeat (3) @(negedge clk);
        model_pulse(1'b0, 1'b0);
        e_trig++;
        check_state(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, wait_cyc, az0;
        bit late_prev, late_next;
        model_reset();

        repeat (5) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Lock: ACPs without ARP leave azimuth at 0, then ARP locks
        for (int i = 0; i < 10; i++) do_pulse("unlocked", 1'b0, 1'b0);
        do_pulse("lock", 1'b1, 1'b0);
        check("lock.rev1", rev_count, 1);

        // Two full revolutions
        for (int i = 0; i < ACP - 1; i++) do_pulse("rev1", 1'b0, 1'b0);
        check("rev1.top", azimuth, ACP - 1);
        do_pulse("idx2", 1'b1, 1'b0);
        for (int i = 0; i < ACP - 1; i++) do_pulse("rev2", 1'b0, 1'b0);
        do_pulse("idx3", 1'b1, 1'b0);
        check("rev2.count", rev_count, 3);
        check("rev2.noerr", cnt_err, 0);

        // Dropped ACP sets the sticky error, a clean revolution keeps it
        for (int i = 0; i < ACP - 2; i++) do_pulse("short", 1'b0, 1'b0);
        do_pulse("short_idx", 1'b1, 1'b0);
        check("short.err", cnt_err, 1);
        for (int i = 0; i < ACP - 1; i++) do_pulse("sticky", 1'b0, 1'b0);
        do_pulse("sticky_idx", 1'b1, 1'b0);
        check("sticky.err", cnt_err, 1);
        pulse_err_clr();

        // Trigger tagging, including a coincident edge at the wrap point
        do_pulse("trg_idx", 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) do_pulse("trg_ramp", 1'b0, 1'b0);
        coinc("coinc40");
        trig_in = 1'b1;
        repeat (2) @(negedge clk);
        trig_in = 1'b0;
        repeat (3) @(negedge clk);
        e_trig++;
        check("lone_trig", trig_az, m_az);
        while (m_az != ACP - 1) do_pulse("trg_ramp2", 1'b0, 1'b0);
        coinc("coinc_wrap");
        do_pulse("trg_end", 1'b1, 1'b0);
        pulse_err_clr();

        // Randomised revolutions: dropped/extra pulses and late ARP
        late_prev = 1'b0;
        for (int r = 0; r < 6; r++) begin
            case ($urandom_range(0, 3))
                0:       n = ACP - 1;
                1:       n = ACP + 1;
                default: n = ACP;
            endcase
            late_next = $urandom_range(0, 1);
            for (int p = 0; p < n; p++)
                do_pulse("rand", (p == 0) && !late_prev, (p == n - 1) && late_next);
            late_prev = late_next;
        end
        do_pulse("rand_end", !late_prev, 1'b0);
        pulse_err_clr();

        // Watchdog: stale exactly WDOG cycles after the last azimuth update
        check("wdog.pre", az_valid, 1);
        wait_cyc = 0;
        while (!stale && wait_cyc < WDOG + 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("wdog.expired", stale, 1);
        check("wdog.delay", cyc - last_az_cyc, WDOG);
        check("wdog.valid", az_valid, 0);
        m_state = 2;
        az0 = m_az;
        do_pulse("stale_acp", 1'b0, 1'b0);
        do_pulse("stale_acp", 1'b0, 1'b0);
        check("stale.frozen", azimuth, az0);
        do_pulse("relock", 1'b1, 1'b0);
        check("relock.az", azimuth, 0);

        // Strobe bookkeeping
        check("cnt.az",   n_az,   e_az);
        check("cnt.rev",  n_rev,  e_rev);
        check("cnt.trig", n_trig, e_trig);
        check("strobe_width", dbl, 0);
`ifdef RADAR_DEC_PERIOD_EN
        check("cnt.period", n_per, e_per);
`else
        check("cnt.period", n_per, 0);
        check("period_off", rev_period, 0);
`endif

        // Reset mid-pulse discards the in-flight edge
        acp_in = 1'b1;
        arp_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        acp_in = 1'b0;
        arp_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        check_zero("midrst.after");
        do_pulse("postrst", 1'b0, 1'b0);

        // Reset also clears a pending ARP
        do_pulse("pend", 1'b0, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        do_pulse("pend_cleared", 1'b0, 1'b0);
        do_pulse("relock2", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
